// File: rtl/lpc_pkg.sv
// Shared LPC record layout, cyctype_dir codes, capture config type and capture state encoding.
package lpc_pkg;

  localparam int DW               = 48;
  localparam int CW               = 10;
  localparam int ADDR_LSB         = 16;
  localparam int ADDR_W           = 32;
  localparam int DATA_LSB         = 8;
  localparam int TRIG_FLAG_BIT    = 5;
  localparam int SYNC_TIMEOUT_BIT = 4;
  localparam int CYC_W            = 4;

  localparam logic [CYC_W-1:0] CYC_IO_READ   = 4'b0000;
  localparam logic [CYC_W-1:0] CYC_IO_WRITE  = 4'b0010;
  localparam logic [CYC_W-1:0] CYC_MEM_READ  = 4'b0100;
  localparam logic [CYC_W-1:0] CYC_MEM_WRITE = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ARMED     = 2'b01,
    ST_TRIGGERED = 2'b10,
    ST_DONE      = 2'b11
  } cap_state_e;

  typedef struct packed {
    logic [15:0]       cyc_mask;
    logic [ADDR_W-1:0] addr_lo;
    logic [ADDR_W-1:0] addr_hi;
    logic [CYC_W-1:0]  trig_cyc;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] trig_addr_mask;
  } cap_cfg_t;

  // An inverted window (lo > hi) naturally admits nothing.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/capture_match.sv
// Combinational record filter and trigger compare against the active capture config.
// Zero latency; no flow control.
module capture_match
  import lpc_pkg::*;
(
  input  logic [CYC_W-1:0]  cyc,
  input  logic [ADDR_W-1:0] addr,
  input  cap_cfg_t          cfg,
  output logic              pass,
  output logic              match
);

  always_comb begin
    pass  = cfg.cyc_mask[cyc] && in_window(addr, cfg.addr_lo, cfg.addr_hi);
    match = (cyc == cfg.trig_cyc) &&
            (((addr ^ cfg.trig_addr) & cfg.trig_addr_mask) == '0);
  end

endmodule

// File: rtl/capture_ctrl.sv
// Arm/trigger/post-trigger capture sequencer gating LPC records into the ringbuffer.
// One-cycle latency in_enable -> out_enable; never stalls, every strobe is handled in its cycle.
module capture_ctrl
  import lpc_pkg::*;
#(
  parameter int DW = lpc_pkg::DW,
  parameter int CW = lpc_pkg::CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_enable,
  input  logic          arm,
  input  logic          disarm,
  input  logic [15:0]   cyc_mask,
  input  logic [31:0]   addr_lo,
  input  logic [31:0]   addr_hi,
  input  logic [3:0]    trig_cyc,
  input  logic [31:0]   trig_addr,
  input  logic [31:0]   trig_addr_mask,
  input  logic [CW-1:0] post_count,
  output logic [DW-1:0] out_data,
  output logic          out_enable,
  output logic [1:0]    state,
  output logic [15:0]   captured
);

  cap_state_e    state_q, state_d, cur_st;
  cap_cfg_t      cfg_q, cfg_d;
  logic [CW-1:0] post_cfg_q, post_cfg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   captured_q, captured_d, cap_base;
  logic [DW-1:0] out_data_q, out_data_d, rec_out;
  logic          out_enable_q, out_enable_d;
  logic          arm_eff, wr, flag, pass, match;

  // A strobe arriving with arm is judged against the config being latched, not the old one.
  always_comb begin
    arm_eff    = arm & ~disarm;
    cfg_d      = cfg_q;
    post_cfg_d = post_cfg_q;
    if (arm_eff) begin
      cfg_d      = '{cyc_mask:       cyc_mask,
                     addr_lo:        addr_lo,
                     addr_hi:        addr_hi,
                     trig_cyc:       trig_cyc,
                     trig_addr:      trig_addr,
                     trig_addr_mask: trig_addr_mask};
      post_cfg_d = post_count;
    end
  end

  capture_match u_match (
    .cyc   (in_data[CYC_W-1:0]),
    .addr  (in_data[ADDR_LSB +: ADDR_W]),
    .cfg   (cfg_d),
    .pass  (pass),
    .match (match)
  );

  always_comb begin
    cur_st   = arm_eff ? ST_ARMED : state_q;
    cap_base = arm_eff ? 16'h0000 : captured_q;
    cnt_d    = arm_eff ? '0 : cnt_q;
    state_d  = cur_st;
    wr       = 1'b0;
    flag     = 1'b0;

    case (cur_st)
      ST_ARMED: begin
        if (in_enable && match) begin
          wr      = 1'b1;
          flag    = 1'b1;
          cnt_d   = post_cfg_d;
          state_d = (post_cfg_d == '0) ? ST_DONE : ST_TRIGGERED;
        end else if (in_enable && pass) begin
          wr = 1'b1;
        end
      end
      ST_TRIGGERED: begin
        if (in_enable && pass) begin
          wr    = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    if (disarm) begin
      state_d = ST_IDLE;
      wr      = 1'b0;
    end

    rec_out                = in_data;
    rec_out[TRIG_FLAG_BIT] = flag;
    out_enable_d = wr;
    out_data_d   = wr ? rec_out : out_data_q;
    captured_d   = (wr && cap_base != 16'hFFFF) ? cap_base + 16'd1 : cap_base;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      post_cfg_q   <= '0;
      cnt_q        <= '0;
      captured_q   <= '0;
      out_data_q   <= '0;
      out_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      post_cfg_q   <= post_cfg_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      out_data_q   <= out_data_d;
      out_enable_q <= out_enable_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_enable = out_enable_q;
  assign state      = state_q;
  assign captured   = captured_q;

endmodule
